// File: rtl/restore_product_checker_if.sv
// Handshake/data bundle for restore_product_checker: input triple side and result side.
interface restore_product_checker_if #(
  parameter int WIDTH = 4
);
  logic                 din_valid;
  logic                 din_ready;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     remainder;
  logic                 dout_valid;
  logic                 dout_ready;
  logic [2*WIDTH-1:0]   dout;
  logic                 overflow;
  logic                 rem_err;

  modport master (
    output din_valid, quotient, divisor, remainder, dout_ready,
    input  din_ready, dout_valid, dout, overflow, rem_err
  );

  modport slave (
    input  din_valid, quotient, divisor, remainder, dout_ready,
    output din_ready, dout_valid, dout, overflow, rem_err
  );
endinterface

// File: rtl/restore_product_checker.sv
// Rebuilds dividend = quotient*divisor + remainder with a serial shift-add, one quotient bit per cycle.
// Optional macro RESTORE_PRODUCT_EARLY_TERM_EN: leave CALC as soon as no quotient bits remain.
module restore_product_checker #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  restore_product_checker_if.slave p_bus
);
  localparam int QW    = 2 * WIDTH;
  localparam int AW    = 3 * WIDTH;
  localparam int CNT_W = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [QW-1:0]     r_q_sr;
  logic [QW-1:0]     w_q_sr_nxt;
  logic [AW-1:0]     r_m_sr;
  logic [AW-1:0]     w_m_sr_nxt;
  logic [AW-1:0]     r_acc;
  logic [AW-1:0]     w_acc_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_din_ready;
  logic              w_din_ready_nxt;
  logic              r_dout_valid;
  logic              w_dout_valid_nxt;
  logic [QW-1:0]     r_dout;
  logic [QW-1:0]     w_dout_nxt;
  logic              r_overflow;
  logic              w_overflow_nxt;
  logic              r_rem_err;
  logic              w_rem_err_nxt;

  logic [AW-1:0]     w_addend;
  logic [AW-1:0]     w_acc_sum;
  logic [QW-1:0]     w_q_shift;
  logic              w_cnt_last;
  logic              w_last;

  // Shift-add datapath: conditional add of the shifted divisor, quotient shifts toward bit 0.
  always_comb begin
    w_addend = '0;
    if (r_q_sr[0]) begin
      w_addend = r_m_sr;
    end else begin
      w_addend = '0;
    end
    w_acc_sum  = r_acc + w_addend;
    w_q_shift  = r_q_sr >> 1;
    w_cnt_last = (r_cnt == CNT_W'(QW - 1));
`ifdef RESTORE_PRODUCT_EARLY_TERM_EN
    w_last     = w_cnt_last || (w_q_shift == '0);
`else
    w_last     = w_cnt_last;
`endif
  end

  // Next-state and next-register values; every register holds unless a state updates it.
  always_comb begin
    w_state_nxt      = r_state;
    w_q_sr_nxt       = r_q_sr;
    w_m_sr_nxt       = r_m_sr;
    w_acc_nxt        = r_acc;
    w_cnt_nxt        = r_cnt;
    w_din_ready_nxt  = r_din_ready;
    w_dout_valid_nxt = r_dout_valid;
    w_dout_nxt       = r_dout;
    w_overflow_nxt   = r_overflow;
    w_rem_err_nxt    = r_rem_err;
    case (r_state)
      ST_IDLE: begin
        if (p_bus.din_valid && r_din_ready) begin
          w_state_nxt      = ST_CALC;
          w_q_sr_nxt       = p_bus.quotient;
          w_m_sr_nxt       = {{QW{1'b0}}, p_bus.divisor};
          w_acc_nxt        = {{QW{1'b0}}, p_bus.remainder};
          w_cnt_nxt        = '0;
          w_rem_err_nxt    = (p_bus.remainder >= p_bus.divisor);
          w_din_ready_nxt  = 1'b0;
          w_dout_valid_nxt = 1'b0;
        end else begin
          w_din_ready_nxt  = 1'b1;
        end
      end
      ST_CALC: begin
        w_acc_nxt  = w_acc_sum;
        w_q_sr_nxt = w_q_shift;
        w_m_sr_nxt = r_m_sr << 1;
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        if (w_last) begin
          w_state_nxt      = ST_DONE;
          w_dout_valid_nxt = 1'b1;
          w_dout_nxt       = w_acc_sum[QW-1:0];
          w_overflow_nxt   = |w_acc_sum[AW-1:QW];
        end else begin
          w_state_nxt      = ST_CALC;
        end
      end
      ST_DONE: begin
        if (p_bus.dout_ready) begin
          w_state_nxt      = ST_IDLE;
          w_dout_valid_nxt = 1'b0;
          w_din_ready_nxt  = 1'b1;
        end else begin
          w_state_nxt      = ST_DONE;
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_din_ready_nxt  = 1'b1;
        w_dout_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_q_sr       <= '0;
      r_m_sr       <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_din_ready  <= 1'b1;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_overflow   <= 1'b0;
      r_rem_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_q_sr       <= w_q_sr_nxt;
      r_m_sr       <= w_m_sr_nxt;
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_din_ready  <= w_din_ready_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_dout       <= w_dout_nxt;
      r_overflow   <= w_overflow_nxt;
      r_rem_err    <= w_rem_err_nxt;
    end
  end

  assign p_bus.din_ready  = r_din_ready;
  assign p_bus.dout_valid = r_dout_valid;
  assign p_bus.dout       = r_dout;
  assign p_bus.overflow   = r_overflow;
  assign p_bus.rem_err    = r_rem_err;
endmodule
